// File: rtl/tx_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tx_port_arbiter
// Brief    : Packet-granular arbiter for one transmit port. Four requesters
//            each present a show-ahead valid FIFO (forward/discard flag per
//            packet) and a show-ahead packet FIFO. The winner's packet is
//            either streamed word-for-word into the shared downstream packet
//            FIFO (followed by one valid write) or drained silently.
// Options  : ARB_PRIO_EN - when defined, requester 0 has strict priority and
//            requesters 1..3 round-robin among themselves; when undefined,
//            plain four-way round-robin.
// Revision : 1.0 - initial release
//==============================================================================
module tx_port_arbiter #(
  parameter logic [8:0] FIFO_THRESH = 9'd350
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   in_valid_empty,
  input  logic [3:0]   in_valid_q,
  output logic [3:0]   in_valid_rdreq,
  input  logic [138:0] in0_pkt_q,
  input  logic [138:0] in1_pkt_q,
  input  logic [138:0] in2_pkt_q,
  input  logic [138:0] in3_pkt_q,
  output logic [3:0]   in_pkt_rdreq,
  output logic         out_pkt_wrreq,
  output logic [138:0] out_pkt,
  input  logic [8:0]   out_pkt_usedw,
  output logic         out_valid_wrreq,
  output logic         out_valid,
  output logic [1:0]   grant_id,
  output logic         busy
);

  // Word-type code carried in bits [138:136]; only the tail ends a packet.
  localparam logic [2:0] C_TYPE_TAIL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRANSMIT = 2'd1,
    S_DISCARD  = 2'd2
  } state_t;

  // Round-robin search: first requester with a pending packet, starting one
  // past the previous winner and wrapping. Returns {found, index}.
  function automatic logic [2:0] f_rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!res[2] && req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Registered state and outputs
  state_t         r_state;
  logic [1:0]     r_last_grant;
  logic [1:0]     r_grant;
  logic [3:0]     r_valid_rdreq;
  logic [3:0]     r_pkt_rdreq;
  logic           r_out_wrreq;
  logic [138:0]   r_out_pkt;
  logic           r_out_valid_wrreq;
  logic           r_out_valid;

  // Next-state values
  state_t         w_state_nxt;
  logic [1:0]     w_last_grant_nxt;
  logic [1:0]     w_grant_nxt;
  logic [3:0]     w_valid_rdreq_nxt;
  logic [3:0]     w_pkt_rdreq_nxt;
  logic           w_out_wrreq_nxt;
  logic [138:0]   w_out_pkt_nxt;
  logic           w_out_valid_wrreq_nxt;
  logic           w_out_valid_nxt;

  // Arbitration and datapath helpers
  logic [3:0]     w_req;
  logic [2:0]     w_pick;
  logic           w_pick_found;
  logic [1:0]     w_pick_idx;
  logic           w_room_ok;
  logic [138:0]   w_pkt_q [4];
  logic [138:0]   w_cur_pkt;
  logic           w_cur_is_tail;

  assign w_pkt_q[0] = in0_pkt_q;
  assign w_pkt_q[1] = in1_pkt_q;
  assign w_pkt_q[2] = in2_pkt_q;
  assign w_pkt_q[3] = in3_pkt_q;

  // A requester is pending whenever its valid FIFO holds a packet flag.
  assign w_req     = ~in_valid_empty;
  // Admission leaves room for a maximum-size packet in the downstream FIFO.
  assign w_room_ok = (out_pkt_usedw < FIFO_THRESH);

`ifdef ARB_PRIO_EN
  // Requester 0 wins outright; otherwise rotate over requesters 1..3 only.
  assign w_pick = w_req[0] ? 3'b100 : f_rr_pick(w_req & 4'b1110, r_last_grant);
`else
  assign w_pick = f_rr_pick(w_req, r_last_grant);
`endif

  assign w_pick_found  = w_pick[2];
  assign w_pick_idx    = w_pick[1:0];

  // The granted requester's FIFO head is the word being moved this cycle.
  assign w_cur_pkt     = w_pkt_q[r_grant];
  assign w_cur_is_tail = (w_cur_pkt[138:136] == C_TYPE_TAIL);

  // Next-state and next-output decode; every strobe defaults low.
  always_comb begin
    w_state_nxt           = S_IDLE;
    w_last_grant_nxt      = r_last_grant;
    w_grant_nxt           = r_grant;
    w_valid_rdreq_nxt     = 4'b0000;
    w_pkt_rdreq_nxt       = 4'b0000;
    w_out_wrreq_nxt       = 1'b0;
    w_out_pkt_nxt         = r_out_pkt;
    w_out_valid_wrreq_nxt = 1'b0;
    w_out_valid_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Grant only with downstream room and a pending requester. The
        // valid flag is consumed here; the packet FIFO read starts now and
        // is held until the tail word.
        if (w_room_ok && w_pick_found) begin
          w_last_grant_nxt  = w_pick_idx;
          w_grant_nxt       = w_pick_idx;
          w_valid_rdreq_nxt = f_onehot(w_pick_idx);
          w_pkt_rdreq_nxt   = f_onehot(w_pick_idx);
          w_state_nxt       = in_valid_q[w_pick_idx] ? S_TRANSMIT : S_DISCARD;
        end
      end

      S_TRANSMIT: begin
        // Every word, including mid-packet header/middle codes, is copied
        // verbatim; the threshold is deliberately not rechecked here.
        w_out_pkt_nxt   = w_cur_pkt;
        w_out_wrreq_nxt = 1'b1;
        if (w_cur_is_tail) begin
          w_out_valid_wrreq_nxt = 1'b1;
          w_out_valid_nxt       = 1'b1;
          w_state_nxt           = S_IDLE;
        end else begin
          w_pkt_rdreq_nxt = f_onehot(r_grant);
          w_state_nxt     = S_TRANSMIT;
        end
      end

      S_DISCARD: begin
        // Drain the packet without touching the downstream FIFOs.
        if (!w_cur_is_tail) begin
          w_pkt_rdreq_nxt = f_onehot(r_grant);
          w_state_nxt     = S_DISCARD;
        end
      end

      default: begin
        // Unused encoding: fall back to IDLE with all strobes low.
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs; reset aborts a packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= S_IDLE;
      r_last_grant      <= 2'd3;
      r_grant           <= 2'd0;
      r_valid_rdreq     <= 4'b0000;
      r_pkt_rdreq       <= 4'b0000;
      r_out_wrreq       <= 1'b0;
      r_out_pkt         <= '0;
      r_out_valid_wrreq <= 1'b0;
      r_out_valid       <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_last_grant      <= w_last_grant_nxt;
      r_grant           <= w_grant_nxt;
      r_valid_rdreq     <= w_valid_rdreq_nxt;
      r_pkt_rdreq       <= w_pkt_rdreq_nxt;
      r_out_wrreq       <= w_out_wrreq_nxt;
      r_out_pkt         <= w_out_pkt_nxt;
      r_out_valid_wrreq <= w_out_valid_wrreq_nxt;
      r_out_valid       <= w_out_valid_nxt;
    end
  end

  assign in_valid_rdreq  = r_valid_rdreq;
  assign in_pkt_rdreq    = r_pkt_rdreq;
  assign out_pkt_wrreq   = r_out_wrreq;
  assign out_pkt         = r_out_pkt;
  assign out_valid_wrreq = r_out_valid_wrreq;
  assign out_valid       = r_out_valid;
  assign grant_id        = r_grant;
  assign busy            = (r_state == S_TRANSMIT) || (r_state == S_DISCARD);

endmodule
`default_nettype wire

// File: tb/tb_tx_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_tx_port_arbiter
// Brief    : Self-checking bench for tx_port_arbiter. Requester FIFOs are
//            modelled as queues; expected output is derived per packet from
//            the arbitration rules and compared with what the DUT writes.
// Revision : 1.0 - initial release
//==============================================================================
module tb_tx_port_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid_empty;
  logic [3:0]   in_valid_q;
  logic [3:0]   in_valid_rdreq;
  logic [138:0] in0_pkt_q, in1_pkt_q, in2_pkt_q, in3_pkt_q;
  logic [3:0]   in_pkt_rdreq;
  logic         out_pkt_wrreq;
  logic [138:0] out_pkt;
  logic [8:0]   out_pkt_usedw;
  logic         out_valid_wrreq;
  logic         out_valid;
  logic [1:0]   grant_id;
  logic         busy;

  always #5 clk = ~clk;

  tx_port_arbiter #(.FIFO_THRESH(9'd350)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid_empty  (in_valid_empty),
    .in_valid_q      (in_valid_q),
    .in_valid_rdreq  (in_valid_rdreq),
    .in0_pkt_q       (in0_pkt_q),
    .in1_pkt_q       (in1_pkt_q),
    .in2_pkt_q       (in2_pkt_q),
    .in3_pkt_q       (in3_pkt_q),
    .in_pkt_rdreq    (in_pkt_rdreq),
    .out_pkt_wrreq   (out_pkt_wrreq),
    .out_pkt         (out_pkt),
    .out_pkt_usedw   (out_pkt_usedw),
    .out_valid_wrreq (out_valid_wrreq),
    .out_valid       (out_valid),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  // Upstream FIFO contents (head at index 0)
  logic [138:0] pq [4][$];
  logic         vq [4][$];

  // Observed and expected streams
  logic [138:0] obs_words [$];
  logic [138:0] exp_words [$];
  int           obs_grants [$];
  int           exp_grants [$];
  int           obs_valid, exp_valid, inv_err, cyc, first_due, refill0;
  bit           in_burst;
  int           prd_cnt [4];
  int           n_checks, n_fail;

  task automatic check(input string tag, input logic [138:0] obs, input logic [138:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    check(tag, 139'(obs), 139'(exp));
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid_empty[i] = (vq[i].size() == 0);
      in_valid_q[i]     = (vq[i].size() != 0) ? vq[i][0] : 1'b0;
    end
    in0_pkt_q = (pq[0].size() != 0) ? pq[0][0] : '0;
    in1_pkt_q = (pq[1].size() != 0) ? pq[1][0] : '0;
    in2_pkt_q = (pq[2].size() != 0) ? pq[2][0] : '0;
    in3_pkt_q = (pq[3].size() != 0) ? pq[3][0] : '0;
  endtask

  // Random packet: header, middles (some coded as header), tail.
  task automatic make_pkt(input int req, input int len, input bit valid);
    logic [138:0] w;
    for (int k = 0; k < len; k++) begin
      w = '0;
      w[127:0]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      w[135:128] = 8'($urandom_range(0, 255));
      if (k == len - 1)  w[138:136] = 3'b110;
      else if (k == 0)   w[138:136] = 3'b101;
      else               w[138:136] = ($urandom_range(0, 3) == 0) ? 3'b101 : 3'b100;
      pq[req].push_back(w);
    end
    vq[req].push_back(valid);
    drive_inputs();
  endtask

  task automatic clear_obs();
    obs_words.delete(); obs_grants.delete();
    obs_valid = 0; inv_err = 0; first_due = 0; in_burst = 0;
    for (int i = 0; i < 4; i++) prd_cnt[i] = 0;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++)
      if (pq[i].size() != 0 || vq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sample outputs on the falling edge, then update the FIFO
  // models just after the rising edge from the strobes that were sampled.
  task automatic tick();
    logic [3:0] s_vrd, s_prd;
    int g;
    @(negedge clk);
    cyc++;
    s_vrd = in_valid_rdreq;
    s_prd = in_pkt_rdreq;
    if (s_vrd != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (s_vrd[i]) g = i;
      if ($countones(s_vrd) != 1 || s_vrd != (4'b0001 << grant_id)) inv_err++;
      obs_grants.push_back(g);
      if (vq[g].size() != 0 && vq[g][0]) first_due = cyc + 1;
    end
    if (s_prd != 4'b0000 && s_prd != (4'b0001 << grant_id)) inv_err++;
    for (int i = 0; i < 4; i++) if (s_prd[i]) prd_cnt[i]++;
    if (out_pkt_wrreq) begin
      obs_words.push_back(out_pkt);
      if (first_due != 0) begin
        if (cyc != first_due) inv_err++;
        first_due = 0;
        in_burst  = 1;
      end else if (!in_burst) begin
        inv_err++;
      end
      if (out_pkt[138:136] == 3'b110) in_burst = 0;
    end else begin
      if (in_burst) inv_err++;
      if (first_due != 0 && cyc >= first_due) begin
        inv_err++;
        first_due = 0;
      end
    end
    if (out_valid_wrreq) begin
      obs_valid++;
      if (out_valid !== 1'b1) inv_err++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (s_prd[i] && pq[i].size() != 0) void'(pq[i].pop_front());
      if (s_vrd[i] && vq[i].size() != 0) void'(vq[i].pop_front());
    end
    if (refill0 > 0 && s_vrd[0]) begin
      make_pkt(0, 3, 1'b1);
      refill0--;
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      if (all_empty() && !busy && !out_pkt_wrreq && !out_valid_wrreq && in_pkt_rdreq == 4'b0000)
        done = 1;
    end
    checki({tag, "_complete"}, int'(done), 1);
  endtask

  // Reference: serve whole packets in arbitration order from a snapshot of
  // the upstream queues; valid packets contribute words and one valid write.
  task automatic build_model(input int last_in);
    logic [138:0] mq [4][$];
    logic         mv [4][$];
    logic [138:0] w;
    int           last, n, c;
    bit           v, done_pkt;
    exp_words.delete(); exp_grants.delete(); exp_valid = 0;
    for (int i = 0; i < 4; i++) begin mq[i] = pq[i]; mv[i] = vq[i]; end
    last = last_in;
    while (1) begin
      n = -1;
`ifdef ARB_PRIO_EN
      if (mv[0].size() != 0) n = 0;
      else
        for (int k = 1; k <= 4; k++) begin
          c = (last + k) % 4;
          if (n < 0 && c != 0 && mv[c].size() != 0) n = c;
        end
`else
      for (int k = 1; k <= 4; k++) begin
        c = (last + k) % 4;
        if (n < 0 && mv[c].size() != 0) n = c;
      end
`endif
      if (n < 0) break;
      last = n;
      exp_grants.push_back(n);
      v = mv[n].pop_front();
      done_pkt = 0;
      while (!done_pkt && mq[n].size() != 0) begin
        w = mq[n].pop_front();
        if (v) exp_words.push_back(w);
        if (w[138:136] == 3'b110) done_pkt = 1;
      end
      if (v) exp_valid++;
    end
  endtask

  task automatic compare_run(input string tag);
    int mism;
    checki({tag, "_nwords"}, obs_words.size(), exp_words.size());
    mism = 0;
    for (int k = 0; k < obs_words.size() && k < exp_words.size(); k++)
      if (obs_words[k] !== exp_words[k]) mism++;
    checki({tag, "_word_mismatches"}, mism, 0);
    checki({tag, "_ngrants"}, obs_grants.size(), exp_grants.size());
    mism = 0;
    for (int k = 0; k < obs_grants.size() && k < exp_grants.size(); k++)
      if (obs_grants[k] != exp_grants[k]) mism++;
    checki({tag, "_grant_order_mismatches"}, mism, 0);
    checki({tag, "_valid_writes"}, obs_valid, exp_valid);
    checki({tag, "_timing_violations"}, inv_err, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin pq[i].delete(); vq[i].delete(); end
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_obs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [138:0] ref_w [3];
    int           exp_order [8];
    int           n;

    n_checks = 0; n_fail = 0; refill0 = 0; cyc = 0;
    out_pkt_usedw = 9'd0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin pq[i].delete(); vq[i].delete(); end
    drive_inputs();
    clear_obs();

    // Reset state
    @(posedge clk);
    #1;
    check("reset_strobes", 139'({in_valid_rdreq, in_pkt_rdreq, out_pkt_wrreq, out_valid_wrreq, out_valid}), 139'(0));
    check("reset_out_pkt", out_pkt, 139'(0));
    checki("reset_grant_id", int'(grant_id), 0);
    checki("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single 3-word valid packet on requester 1
    ref_w[0] = '0; ref_w[0][138:136] = 3'b101; ref_w[0][127:0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    ref_w[1] = '0; ref_w[1][138:136] = 3'b100; ref_w[1][127:0] = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    ref_w[2] = '0; ref_w[2][138:136] = 3'b110; ref_w[2][135:132] = 4'h7;
    ref_w[2][127:0] = 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978;
    for (int k = 0; k < 3; k++) pq[1].push_back(ref_w[k]);
    vq[1].push_back(1'b1);
    drive_inputs();
    clear_obs();
    run_until_idle("single", 50);
    checki("single_nwords", obs_words.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("single_word%0d", k), (obs_words.size() > k) ? obs_words[k] : 139'(0), ref_w[k]);
    checki("single_valid_writes", obs_valid, 1);
    checki("single_grant_id", int'(grant_id), 1);
    checki("single_timing_violations", inv_err, 0);

    // Discarded 5-word packet on requester 2
    make_pkt(2, 5, 1'b0);
    clear_obs();
    run_until_idle("discard", 50);
    checki("discard_rdreq2_cycles", prd_cnt[2], 5);
    checki("discard_other_rdreq", prd_cnt[0] + prd_cnt[1] + prd_cnt[3], 0);
    checki("discard_wrreq_words", obs_words.size(), 0);
    checki("discard_valid_writes", obs_valid, 0);
    checki("discard_busy_after", int'(busy), 0);

    // Threshold: blocked at 350, admitted at 349, not rechecked mid-packet
    out_pkt_usedw = 9'd350;
    make_pkt(0, 4, 1'b1);
    clear_obs();
    repeat (6) tick();
    checki("thresh_blocked_grants", obs_grants.size(), 0);
    checki("thresh_blocked_busy", int'(busy), 0);
    build_model(2);
    out_pkt_usedw = 9'd349;
    tick();
    tick();
    checki("thresh_grant_after_drop", obs_grants.size(), 1);
    out_pkt_usedw = 9'd400;
    run_until_idle("thresh", 50);
    compare_run("thresh");
    out_pkt_usedw = 9'd0;

    // Four requesters with two valid packets each
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 4; r++) make_pkt(r, $urandom_range(2, 5), 1'b1);
    build_model(3);
`ifdef ARB_PRIO_EN
    exp_order = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    run_until_idle("rr4", 300);
    compare_run("rr4");
    n = 0;
    for (int k = 0; k < 8; k++)
      if (k >= obs_grants.size() || obs_grants[k] != exp_order[k]) n++;
    checki("rr4_fixed_order_mismatches", n, 0);

`ifdef ARB_PRIO_EN
    // Requester 0 refilled during each of its transfers starves requester 3
    do_reset();
    make_pkt(0, 3, 1'b1);
    make_pkt(3, 3, 1'b1);
    refill0 = 3;
    run_until_idle("prio", 200);
    exp_order[0:4] = '{0, 0, 0, 0, 3};
    n = 0;
    for (int k = 0; k < 5; k++)
      if (k >= obs_grants.size() || obs_grants[k] != exp_order[k]) n++;
    checki("prio_order_mismatches", n, 0);
    checki("prio_ngrants", obs_grants.size(), 5);
    checki("prio_nwords", obs_words.size(), 15);
    checki("prio_valid_writes", obs_valid, 5);
    checki("prio_timing_violations", inv_err, 0);
    refill0 = 0;
`endif

    // Randomized rounds
    for (int round = 0; round < 4; round++) begin
      do_reset();
      out_pkt_usedw = 9'($urandom_range(0, 349));
      for (int r = 0; r < 4; r++) begin
        n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++) make_pkt(r, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
      end
      build_model(3);
      run_until_idle($sformatf("rand%0d", round), 600);
      compare_run($sformatf("rand%0d", round));
    end
    out_pkt_usedw = 9'd0;

    // Reset on the second word of a 10-word packet
    do_reset();
    make_pkt(1, 10, 1'b1);
    n = 0;
    while (obs_words.size() < 1 && n < 20) begin tick(); n++; end
    checki("abort_first_word_seen", obs_words.size(), 1);
    checki("abort_second_word_pending", int'(out_pkt_wrreq), 1);
    reset = 1'b0;
    #1;
    check("abort_strobes", 139'({in_valid_rdreq, in_pkt_rdreq, out_pkt_wrreq, out_valid_wrreq, out_valid}), 139'(0));
    checki("abort_busy", int'(busy), 0);
    checki("abort_valid_writes", obs_valid, 0);
    for (int i = 0; i < 4; i++) begin pq[i].delete(); vq[i].delete(); end
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clear_obs();
    make_pkt(3, 2, 1'b1);
    make_pkt(1, 2, 1'b1);
    make_pkt(0, 2, 1'b1);
    build_model(3);
    run_until_idle("post_abort", 100);
    checki("post_abort_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);
    compare_run("post_abort");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_port_arbiter.md
TX_PORT_ARBITER -- requirements
Module: tx_port_arbiter

Interface
REQ-001 Parameter FIFO_THRESH, default 9'd350: admit a new packet only while out_pkt_usedw < FIFO_THRESH (leaves room for a 161-word maximum packet).
REQ-002 clk  input  1  clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid_empty  input  4  per-requester valid-FIFO empty flag; bit n belongs to requester n.
REQ-005 in_valid_q  input  4  per-requester show-ahead valid-FIFO head: 1 = forward the packet, 0 = discard it.
REQ-006 in_valid_rdreq  output  4  per-requester valid-FIFO read strobe.
REQ-007 in0_pkt_q..in3_pkt_q  input  139 each  show-ahead packet-FIFO heads; [138:136] 101 header, 100 middle, 110 tail; [135:132] tail byte count minus 1; [127:0] data.
REQ-008 in_pkt_rdreq  output  4  per-requester packet-FIFO read strobe.
REQ-009 out_pkt_wrreq  output  1  write strobe to the shared downstream packet FIFO, which feeds the port CRC generator.
REQ-010 out_pkt  output  139  packet word to the downstream FIFO.
REQ-011 out_pkt_usedw  input  9  downstream packet-FIFO fill level.
REQ-012 out_valid_wrreq, out_valid  output  1 each  downstream valid-FIFO write strobe and value.
REQ-013 grant_id  output  2  requester currently or most recently served; busy  output  1  high in TRANSMIT and DISCARD.

Function
REQ-014 States: IDLE, TRANSMIT, DISCARD; any other encoding returns to IDLE on the next clock.
REQ-015 IDLE entry condition:
- out_pkt_usedw < FIFO_THRESH, and
- at least one in_valid_empty bit is 0.
If either fails, the block stays in IDLE and drives no strobes.
REQ-016 Grant selection:
- round-robin over non-empty requesters;
- search starts at last_grant+1 modulo 4;
- the winner n is registered into last_grant and grant_id.
REQ-017 In the grant cycle the block registers:
- in_valid_rdreq[n] = 1 for exactly one clock;
- in_pkt_rdreq[n] = 1;
- next state TRANSMIT if in_valid_q[n] = 1, otherwise DISCARD.
REQ-018 TRANSMIT, every clock:
- out_pkt <= in<n>_pkt_q;
- out_pkt_wrreq <= 1;
- in_pkt_rdreq[n] stays 1.
REQ-019 TRANSMIT, when in<n>_pkt_q[138:136] = 110 (tail):
- the tail word is written;
- in_pkt_rdreq[n] <= 0;
- out_valid_wrreq <= 1 and out_valid <= 1 for one clock;
- next state IDLE.
REQ-020 DISCARD:
- in_pkt_rdreq[n] = 1 and out_pkt_wrreq = 0 every clock;
- on the tail, in_pkt_rdreq[n] <= 0 and next state IDLE;
- out_valid_wrreq is never asserted for a discarded packet.
REQ-021 Latency: the first output word appears 2 clocks after the IDLE cycle in which the grant is made; the following words stream one per clock, and there are no gaps inside a packet.
REQ-022 Arbitration is packet-granular; a packet is never interleaved with another requester's words.
REQ-023 Only the tail word ends a packet; header or middle words seen mid-packet are passed through unchanged.
REQ-024 The threshold is checked only in IDLE; a transmission in progress is never stalled.
REQ-025 Only the bit of the granted requester n is ever asserted in in_pkt_rdreq and in_valid_rdreq.
REQ-026 In IDLE, out_pkt_wrreq = 0 and out_valid_wrreq = 0.
REQ-027 After a tail, at least one IDLE cycle separates consecutive packets.

Reset
REQ-028 While reset = 0, the block SHALL hold:
- state IDLE;
- all rdreq and wrreq strobes 0;
- out_valid = 0, out_pkt = 0;
- grant_id = 0, busy = 0;
- last_grant = 3, so that the first grant goes to requester 0.
REQ-029 A reset asserted mid-packet SHALL abort the packet immediately with no valid write; upstream and downstream FIFOs share the same clear.

Configuration
REQ-030 Macro ARB_PRIO_EN.
- Defined: requester 0 has strict priority and is granted whenever its valid FIFO is non-empty; requesters 1-3 round-robin among themselves only when requester 0 is empty.
- Not defined: pure four-way round-robin per REQ-016.

Verification
REQ-031 Requester 1 holds one 3-word valid packet (101/100/110, tail nibble 4'h7); others empty; usedw = 0 -> three out_pkt_wrreq words identical to the input, one out_valid_wrreq with out_valid = 1, grant_id = 1.
REQ-032 All four requesters each hold two valid packets; ARB_PRIO_EN undefined -> grant order 0,1,2,3,0,1,2,3 with no interleaved words.
REQ-033 Requester 2 packet with valid = 0, 5 words -> 5 reads on in_pkt_rdreq[2], zero out_pkt_wrreq, zero out_valid_wrreq, then IDLE.
REQ-034 usedw = 350 with a pending packet -> no grant; drop usedw to 349 -> grant within 1 clock.
REQ-035 ARB_PRIO_EN defined; requesters 0 and 3 both pending, and requester 0 gets a new packet during each transfer -> requester 0 is served repeatedly and requester 3 waits until queue 0 is empty.
REQ-036 Reset asserted on the 2nd word of a 10-word packet -> all strobes 0 in the same clock, no out_valid_wrreq; after release, the first grant goes to requester 0.
